// File: rtl/serial_deser.sv
// serial_deser: serial-in, parallel-out deserializer with a registered
// valid/ready output stage. Optional feature macro: PARITY_CHK_EN
// (adds an even-parity bit to every frame and the parity_err output).
module serial_deser #(
    parameter int WIDTH     = 6,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             busy,
    output logic             overrun
`ifdef PARITY_CHK_EN
    ,
    output logic             parity_err
`endif
);

`ifdef PARITY_CHK_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_word;
    logic [WIDTH-1:0] word;
    logic             complete;
    logic [WIDTH-1:0] par_out_q;
    logic             par_valid_q;
    logic             overrun_q;
`ifdef PARITY_CHK_EN
    logic             word_perr;
    logic             parity_err_q;
`endif

    // FSM state, bit counter and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Next-state logic: start/abort on frame_start, shift on valid bits, detect completion
    always_comb begin
        shifted    = MSB_FIRST ? {shreg_q[WIDTH-2:0], ser_in} : {ser_in, shreg_q[WIDTH-1:1]};
        first_word = MSB_FIRST ? {{(WIDTH-1){1'b0}}, ser_in} : {ser_in, {(WIDTH-1){1'b0}}};
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        complete   = 1'b0;
`ifdef PARITY_CHK_EN
        word       = shreg_q;
        word_perr  = (^shreg_q) ^ ser_in;
`else
        word       = shifted;
`endif
        if (ser_valid) begin
            if (frame_start) begin
                state_d = SHIFT;
                cnt_d   = CW'(1);
                shreg_d = first_word;
            end else if (state_q == SHIFT) begin
                if (cnt_q == LAST_CNT) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                    shreg_d  = word;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    shreg_d = shifted;
                end
            end
        end
    end

    // Output register: load on completion when free or being accepted, else flag overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_out_q    <= '0;
            par_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef PARITY_CHK_EN
            parity_err_q <= 1'b0;
`endif
        end else if (complete) begin
            if (!par_valid_q || par_ready) begin
                par_out_q    <= word;
                par_valid_q  <= 1'b1;
`ifdef PARITY_CHK_EN
                parity_err_q <= word_perr;
`endif
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (par_valid_q && par_ready) begin
            par_valid_q <= 1'b0;
        end
    end

    // Output decode: busy follows the registered state, the rest mirror their registers
    always_comb begin
        busy       = (state_q == SHIFT);
        par_out    = par_out_q;
        par_valid  = par_valid_q;
        overrun    = overrun_q;
`ifdef PARITY_CHK_EN
        parity_err = parity_err_q;
`endif
    end

endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser: directed bench for serial_deser, one MSB-first and one
// LSB-first instance driven by the same serial stream.
module tb_serial_deser;

`ifdef PARITY_CHK_EN
    localparam int NBITS = 7;
`else
    localparam int NBITS = 6;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_in = 1'b0;
    logic       ser_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic       par_ready = 1'b0;
    logic [5:0] outM, outL;
    logic       validM, validL, busyM, busyL, ovrM, ovrL;
`ifdef PARITY_CHK_EN
    logic       perrM, perrL;
`endif
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    serial_deser #(.WIDTH(6), .MSB_FIRST(1'b1)) dutM (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
        .frame_start(frame_start), .par_out(outM), .par_valid(validM),
        .par_ready(par_ready), .busy(busyM), .overrun(ovrM)
`ifdef PARITY_CHK_EN
        , .parity_err(perrM)
`endif
    );

    serial_deser #(.WIDTH(6), .MSB_FIRST(1'b0)) dutL (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
        .frame_start(frame_start), .par_out(outL), .par_valid(validL),
        .par_ready(par_ready), .busy(busyL), .overrun(ovrL)
`ifdef PARITY_CHK_EN
        , .parity_err(perrL)
`endif
    );

    task automatic sendBit(input logic b, input logic fs, input logic v);
        ser_in = b;
        frame_start = fs;
        ser_valid = v;
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
        frame_start = 1'b0;
        ser_in = 1'b0;
    endtask

    // seq[5] is transmitted first; a correct parity bit is appended when enabled
    task automatic sendFrame(input logic [5:0] seq, input logic readyLast);
        logic [6:0] bits;
        bits = {seq, ^seq};
        for (int i = 0; i < NBITS; i++) begin
            if (i == NBITS - 1) par_ready = readyLast;
            sendBit(bits[6-i], (i == 0), 1'b1);
        end
        par_ready = 1'b0;
    endtask

    task automatic acceptWord();
        par_ready = 1'b1;
        @(posedge clk);
        #1;
        par_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({outM, validM, busyM, ovrM} !== 9'b0) $display("[TB] FAIL reset_M: got %b expected 0", {outM, validM, busyM, ovrM}); else passed++;
        checks++; if ({outL, validL, busyL, ovrL} !== 9'b0) $display("[TB] FAIL reset_L: got %b expected 0", {outL, validL, busyL, ovrL}); else passed++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_bit_order();
        logic [5:0] seqs [2];
        logic [5:0] expM [2];
        logic [5:0] expL [2];
        seqs[0] = 6'b001000; expM[0] = 6'b001000; expL[0] = 6'b000100;
        seqs[1] = 6'b110000; expM[1] = 6'b110000; expL[1] = 6'b000011;
        for (int k = 0; k < 2; k++) begin
            logic [6:0] bits;
            bits = {seqs[k], ^seqs[k]};
            for (int i = 0; i < NBITS - 1; i++) sendBit(bits[6-i], (i == 0), 1'b1);
            checks++; if (validM !== 1'b0 || busyM !== 1'b1) $display("[TB] FAIL pre_last_%0d: valid=%b busy=%b expected valid=0 busy=1", k, validM, busyM); else passed++;
            sendBit(bits[7-NBITS], 1'b0, 1'b1);
            checks++; if (validM !== 1'b1 || outM !== expM[k]) $display("[TB] FAIL word_M_%0d: got valid=%b %b expected 1 %b", k, validM, outM, expM[k]); else passed++;
            checks++; if (validL !== 1'b1 || outL !== expL[k]) $display("[TB] FAIL word_L_%0d: got valid=%b %b expected 1 %b", k, validL, outL, expL[k]); else passed++;
            checks++; if (busyM !== 1'b0) $display("[TB] FAIL idle_after_%0d: busy=%b expected 0", k, busyM); else passed++;
            acceptWord();
            checks++; if (validM !== 1'b0 || validL !== 1'b0) $display("[TB] FAIL accept_%0d: valid=%b%b expected 00", k, validM, validL); else passed++;
        end
    endtask

    task automatic test_stall();
        logic [6:0] bits;
        bits = {6'b100110, ^6'b100110};
        for (int i = 0; i < NBITS; i++) begin
            sendBit(bits[6-i], (i == 0), 1'b1);
            if (i < NBITS - 1) begin
                sendBit(~bits[6-i], 1'b1, 1'b0);
                checks++; if (busyM !== 1'b1 || validM !== 1'b0) $display("[TB] FAIL stall_%0d: busy=%b valid=%b expected busy=1 valid=0", i, busyM, validM); else passed++;
            end
        end
        checks++; if (validM !== 1'b1 || outM !== 6'b100110) $display("[TB] FAIL stall_word_M: got %b %b expected 1 100110", validM, outM); else passed++;
        checks++; if (outL !== 6'b011001) $display("[TB] FAIL stall_word_L: got %b expected 011001", outL); else passed++;
        acceptWord();
    endtask

    task automatic test_overrun();
        sendFrame(6'b101010, 1'b0);
        sendFrame(6'b010011, 1'b0);
        checks++; if (validM !== 1'b1 || outM !== 6'b101010) $display("[TB] FAIL drop_keep_M: got %b %b expected 1 101010", validM, outM); else passed++;
        checks++; if (outL !== 6'b010101) $display("[TB] FAIL drop_keep_L: got %b expected 010101", outL); else passed++;
        checks++; if (ovrM !== 1'b1 || ovrL !== 1'b1) $display("[TB] FAIL overrun_set: got %b%b expected 11", ovrM, ovrL); else passed++;
        @(posedge clk); #1;
        checks++; if (ovrM !== 1'b1) $display("[TB] FAIL overrun_sticky: got %b expected 1", ovrM); else passed++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        sendFrame(6'b101010, 1'b0);
        sendFrame(6'b010011, 1'b1);
        checks++; if (validM !== 1'b1 || outM !== 6'b010011) $display("[TB] FAIL same_edge_M: got %b %b expected 1 010011", validM, outM); else passed++;
        checks++; if (outL !== 6'b110010) $display("[TB] FAIL same_edge_L: got %b expected 110010", outL); else passed++;
        checks++; if (ovrM !== 1'b0 || ovrL !== 1'b0) $display("[TB] FAIL same_edge_ovr: got %b%b expected 00", ovrM, ovrL); else passed++;
        acceptWord();
    endtask

    task automatic test_abort();
        sendBit(1'b1, 1'b1, 1'b1);
        sendBit(1'b1, 1'b0, 1'b1);
        sendBit(1'b1, 1'b0, 1'b1);
        checks++; if (busyM !== 1'b1) $display("[TB] FAIL abort_busy: got %b expected 1", busyM); else passed++;
        sendFrame(6'b011001, 1'b0);
        checks++; if (validM !== 1'b1 || outM !== 6'b011001) $display("[TB] FAIL abort_word_M: got %b %b expected 1 011001", validM, outM); else passed++;
        checks++; if (outL !== 6'b100110 || ovrM !== 1'b0) $display("[TB] FAIL abort_word_L: got %b ovr=%b expected 100110 ovr=0", outL, ovrM); else passed++;
        acceptWord();
    endtask

    task automatic test_async_reset();
        sendFrame(6'b111000, 1'b0);
        sendFrame(6'b000111, 1'b0);
        sendBit(1'b1, 1'b1, 1'b1);
        sendBit(1'b0, 1'b0, 1'b1);
        checks++; if (validM !== 1'b1 || ovrM !== 1'b1 || busyM !== 1'b1) $display("[TB] FAIL pre_reset: got v=%b o=%b b=%b expected 111", validM, ovrM, busyM); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({outM, validM, busyM, ovrM} !== 9'b0) $display("[TB] FAIL async_reset_M: got %b expected 0", {outM, validM, busyM, ovrM}); else passed++;
        checks++; if ({outL, validL, busyL, ovrL} !== 9'b0) $display("[TB] FAIL async_reset_L: got %b expected 0", {outL, validL, busyL, ovrL}); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) sendBit(1'b1, 1'b0, 1'b1);
        checks++; if (validM !== 1'b0 || busyM !== 1'b0) $display("[TB] FAIL idle_ignore: valid=%b busy=%b expected 00", validM, busyM); else passed++;
    endtask

`ifdef PARITY_CHK_EN
    task automatic test_parity();
        logic [6:0] good;
        logic [6:0] bad;
        good = 7'b0010001;
        bad  = 7'b0010000;
        for (int i = 0; i < 7; i++) sendBit(good[6-i], (i == 0), 1'b1);
        checks++; if (validM !== 1'b1 || outM !== 6'b001000 || perrM !== 1'b0) $display("[TB] FAIL parity_good: got %b %b err=%b expected 1 001000 0", validM, outM, perrM); else passed++;
        acceptWord();
        for (int i = 0; i < 7; i++) sendBit(bad[6-i], (i == 0), 1'b1);
        checks++; if (validM !== 1'b1 || outM !== 6'b001000 || perrM !== 1'b1) $display("[TB] FAIL parity_bad: got %b %b err=%b expected 1 001000 1", validM, outM, perrM); else passed++;
        checks++; if (perrL !== 1'b1) $display("[TB] FAIL parity_bad_L: got %b expected 1", perrL); else passed++;
        acceptWord();
    endtask
`endif

    initial begin
        test_reset();
        test_bit_order();
        test_stall();
        test_overrun();
        test_abort();
`ifdef PARITY_CHK_EN
        test_parity();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
